// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data and fetch ports share one single-outstanding memory port.
// Data has priority, but fetch wins after STARVE_MAX back-to-back data grants with fetch pending.
module mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [3:0]      d_be,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_err,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_err,
  output logic            m_req,
  output logic            m_we,
  output logic [3:0]      m_be,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic            m_ack,
  input  logic [XLEN-1:0] m_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic            owner_fetch;
  logic [SW-1:0]   starve_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            fetch_win, done_ack, done_to;
  logic [XLEN-1:0] done_rdata;

  assign m_req = (state == BUSY);

  always_comb begin
    state_nxt  = state;
    d_gnt      = 1'b0;
    i_gnt      = 1'b0;
    done_ack   = 1'b0;
    done_to    = 1'b0;
    fetch_win  = i_req && (!d_req || starve_cnt == SW'(STARVE_MAX));
    case (state)
      IDLE: begin
        // grants are masked while reset is held so every output reads 0
        if (!rst) begin
          i_gnt = fetch_win;
          d_gnt = d_req && !fetch_win;
        end
        if (d_gnt || i_gnt) state_nxt = BUSY;
      end
      BUSY: begin
        done_ack = m_ack;
        done_to  = !m_ack && (wait_cnt == WW'(TIMEOUT - 1));
        if (done_ack || done_to) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    done_rdata = (done_ack && !m_we) ? m_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner_fetch <= 1'b0;
      starve_cnt  <= '0;
      wait_cnt    <= '0;
      m_we        <= 1'b0;
      m_be        <= '0;
      m_addr      <= '0;
      m_wdata     <= '0;
      d_rvalid    <= 1'b0;
      d_err       <= 1'b0;
      d_rdata     <= '0;
      i_rvalid    <= 1'b0;
      i_err       <= 1'b0;
      i_rdata     <= '0;
    end else begin
      state    <= state_nxt;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;

      if (d_gnt || i_gnt) begin
        owner_fetch <= i_gnt;
        m_we        <= d_gnt & d_we;
        m_be        <= i_gnt ? 4'hF : d_be;
        m_addr      <= i_gnt ? i_addr : d_addr;
        m_wdata     <= i_gnt ? '0 : d_wdata;
        wait_cnt    <= '0;
      end else if (state == BUSY && !m_ack) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (i_gnt)
        starve_cnt <= '0;
      else if (d_gnt && i_req && starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;

      if (done_ack || done_to) begin
        if (owner_fetch) begin
          i_rvalid <= 1'b1;
          i_err    <= done_to;
          i_rdata  <= done_rdata;
        end else begin
          d_rvalid <= 1'b1;
          d_err    <= done_to;
          d_rdata  <= done_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: transaction-level reference model predicts grants,
// memory-port payload and completion cycle/data; a separate monitor pops and compares completions.
module tb_mem_arbiter;
  localparam int XLEN = 32;
  localparam int SMAX = 4;
  localparam int TOUT = 15;

  logic            clk = 1'b0, rst = 1'b1;
  logic            d_req = 0, d_we = 0, i_req = 0, m_ack = 0;
  logic [3:0]      d_be = '0;
  logic [XLEN-1:0] d_addr = '0, d_wdata = '0, i_addr = '0, m_rdata = '0;
  logic            d_gnt, d_rvalid, d_err, i_gnt, i_rvalid, i_err, m_req, m_we;
  logic [XLEN-1:0] d_rdata, i_rdata, m_addr, m_wdata;
  logic [3:0]      m_be;

  mem_arbiter #(.XLEN(XLEN), .STARVE_MAX(SMAX), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              fetch;
    bit              we;
    logic [3:0]      be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    bit              err;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0, failures = 0;
  int   cyc = 0;
  int   next_lat = 2, pend_lat = 0;
  int   g_cyc = -1, done_cyc = 0, starve = 0;
  logic [XLEN-1:0] exp_d_rd = '0, exp_i_rd = '0;

  function automatic logic [XLEN-1:0] mem_val(input logic [XLEN-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic int rand_lat();
    int r;
    r = int'($urandom % 8);
    if (r < 4)       return int'($urandom_range(0, 3));
    else if (r == 4) return TOUT - 1;
    else if (r == 5) return int'($urandom_range(TOUT, TOUT + 2));
    else             return int'($urandom_range(4, TOUT - 2));
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // memory responder: ack after pend_lat wait cycles, stray acks while idle
  int bcnt = 0;
  always @(posedge clk) begin
    #1;
    if (m_req) begin
      bcnt++;
      m_ack   = (bcnt == pend_lat + 1);
      m_rdata = m_ack ? mem_val(m_addr) : $urandom;
    end else begin
      bcnt    = 0;
      m_ack   = ($urandom % 6 == 0);
      m_rdata = $urandom;
    end
  end

  // reference model: grants, busy window, payload; pushes predicted completions
  always @(negedge clk) begin
    if (cyc >= 1) begin
      bit busy, free, eg_d, eg_i;
      exp_t e;
      int n;
      busy = (cyc > g_cyc) && (cyc < done_cyc);
      free = (cyc >= done_cyc);
      eg_d = 0; eg_i = 0;
      if (free && !rst) begin
        if (i_req && (!d_req || starve == SMAX)) eg_i = 1;
        else if (d_req)                          eg_d = 1;
      end
      chk("d_gnt", 32'(d_gnt), 32'(eg_d));
      chk("i_gnt", 32'(i_gnt), 32'(eg_i));
      chk("m_req", 32'(m_req), 32'(busy));
      if (busy) begin
        chk("m_we", 32'(m_we), 32'(cur.we));
        chk("m_be", 32'(m_be), 32'(cur.be));
        chk("m_addr", m_addr, cur.addr);
        if (cur.we) chk("m_wdata", m_wdata, cur.wdata);
      end
      if (rst) begin
        if (done_cyc > cyc + 1) done_cyc = cyc + 1;
        starve = 0;
        while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
      end else if (eg_d || eg_i) begin
        e.fetch = eg_i;
        e.we    = eg_d && d_we;
        e.be    = eg_i ? 4'hF : d_be;
        e.addr  = eg_i ? i_addr : d_addr;
        e.wdata = d_wdata;
        e.err   = (next_lat >= TOUT);
        e.rdata = (e.err || e.we) ? '0 : mem_val(e.addr);
        n       = (next_lat < TOUT) ? next_lat + 1 : TOUT;
        e.cyc   = cyc + n + 1;
        sb.push_back(e);
        cur      = e;
        g_cyc    = cyc;
        done_cyc = e.cyc;
        pend_lat = next_lat;
        next_lat = rand_lat();
        if (eg_i)              starve = 0;
        else if (i_req && starve < SMAX) starve++;
      end
    end
  end

  // monitor: pops predicted completions when the DUT presents one
  always @(negedge clk) begin
    if (cyc >= 1) begin
      exp_t e;
      if (d_rvalid && i_rvalid) chk("both_rvalid", 32'(1), 32'(0));
      chk("d_err_alone", 32'(d_err && !d_rvalid), 32'(0));
      chk("i_err_alone", 32'(i_err && !i_rvalid), 32'(0));
      if (d_rvalid || i_rvalid) begin
        if (sb.size() == 0) begin
          chk("spurious_rvalid", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("rvalid_owner", 32'(i_rvalid), 32'(e.fetch));
          chk("rvalid_cycle", 32'(cyc), 32'(e.cyc));
          chk("err", 32'(e.fetch ? i_err : d_err), 32'(e.err));
          if (e.fetch) exp_i_rd = e.rdata; else exp_d_rd = e.rdata;
        end
      end else begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          chk("missing_rvalid_cycle", 32'(cyc), 32'(e.cyc - 1));
        end
      end
      chk("d_rdata", d_rdata, exp_d_rd);
      chk("i_rdata", i_rdata, exp_i_rd);
      if (rst) begin exp_d_rd = '0; exp_i_rd = '0; end
    end
  end

  task automatic new_d();
    d_we    = $urandom;
    d_be    = $urandom;
    d_addr  = {$urandom_range(0, 255), 2'b00};
    d_wdata = $urandom;
  endtask

  task automatic new_i();
    i_addr = {$urandom_range(0, 1023), 2'b00};
  endtask

  initial begin
    logic dg, ig;
    string seq;
    int k;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 d_req = 1; i_req = 1; new_d(); new_i();
    @(negedge clk);
    chk("reset_outputs", 32'({d_gnt, i_gnt, m_req, m_we, d_rvalid, i_rvalid, d_err, i_err,
                              |m_be, |m_addr, |m_wdata, |d_rdata, |i_rdata}), 32'(0));
    @(posedge clk); #1 rst = 0;

    for (int j = 0; j < 3000; j++) begin
      @(negedge clk); dg = d_gnt; ig = i_gnt;
      @(posedge clk); #1;
      rst = ($urandom % 100 == 0);
      if (!d_req || dg) begin d_req = ($urandom % 3 != 0); new_d(); end
      if (!i_req || ig) begin i_req = ($urandom % 3 != 0); new_i(); end
    end

    // both requesters held high from a fresh reset: fixed grant pattern
    rst = 1; d_req = 0; i_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0; d_req = 1; i_req = 1; new_d(); new_i();
    seq = "";
    k = 0;
    while (seq.len() < 10 && k < 600) begin
      @(negedge clk);
      dg = d_gnt; ig = i_gnt;
      if (dg) seq = {seq, "D"};
      if (ig) seq = {seq, "I"};
      @(posedge clk); #1;
      if (dg) new_d();
      if (ig) new_i();
      k++;
    end
    checks++;
    if (seq != "DDDDIDDDDI") begin
      failures++;
      $display("FAIL grant_sequence: got %s expected DDDDIDDDDI", seq);
    end

    d_req = 0; i_req = 0;
    k = 0;
    while (sb.size() > 0 && k < 60) begin @(posedge clk); k++; end
    chk("drain_outstanding", 32'(sb.size()), 32'(0));
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
